// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder: one full-adder cell, registered carry, start/done handshake
// Optional subtract mode enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b, res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_c;
  logic             accept, last;
  logic [WIDTH-1:0] load_b;
  logic             load_c;

  assign fa_s = op_a[0] ^ op_b[0] ^ carry;
  assign fa_c = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
  assign last = (cnt == CW'(WIDTH - 1));

  // Subtraction is a + ~b + 1, so only the loaded operand and carry differ.
`ifdef SERIAL_ADDER_SUB_EN
  assign load_b = sub ? ~b : b;
  assign load_c = sub ? 1'b1 : cin;
`else
  assign load_b = b;
  assign load_c = cin;
`endif

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= load_b;
      res   <= '0;
      carry <= load_c;
      cnt   <= '0;
    end else if (state == RUN) begin
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      res   <= {fa_s, res[WIDTH-1:1]};
      carry <= fa_c;
      cnt   <= cnt + CW'(1);
      // Publish only the completed word so sum never shows partial bits.
      if (last) begin
        sum  <= {fa_s, res[WIDTH-1:1]};
        cout <= fa_c;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial ripple adder that sums two WIDTH-bit operands one bit per clock through a single full-adder cell and a registered carry. It sits beside the combinational full adder: the adder cell is the per-bit datapath and this block adds operand shifting, carry storage, sequencing and a start/done handshake. The result is a registered sum plus carry-out. It trades area for latency in narrow datapaths.

## Interface

Parameters:
- WIDTH, default 8: operand and sum width. Legal values are WIDTH >= 2.

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request to begin an addition; sampled only in IDLE or DONE
- a  input  WIDTH  operand A; captured on an accepted start
- b  input  WIDTH  operand B; captured on an accepted start
- cin  input  1  carry-in; captured on an accepted start
- sub  input  1  subtract select; present only with SERIAL_ADDER_SUB_EN
- busy  output  1  high while state is RUN
- done  output  1  one-cycle pulse while state is DONE
- sum  output  WIDTH  registered result; held between completions
- cout  output  1  registered carry-out of the MSB; held between completions

## Operation

- States: IDLE, RUN, DONE.
- Reset, on any edge with rst=1, regardless of state:
  - state goes to IDLE.
  - busy, done, sum and cout all become 0.
  - Internal shift registers, carry flop and bit counter clear.
  - rst has priority over start.
- IDLE with start=1:
  - Load a and b into shift registers.
  - Carry flop <= cin.
  - Counter <= 0.
  - Go to RUN.
- IDLE with start=0: stay in IDLE.
- RUN, every cycle:
  - Full adder takes opA[0], opB[0] and the carry flop.
  - Its sum bit shifts into the MSB of the internal result shift register.
  - opA and opB shift right.
  - Carry flop <= adder carry.
  - Counter increments.
- RUN exit: on the edge where counter = WIDTH-1:
  - sum <= completed result.
  - cout <= final carry.
  - Go to DONE.
- DONE, exactly one cycle:
  - done=1.
  - If start=1: accept new operands exactly as from IDLE and go to RUN.
  - Otherwise go to IDLE.
- start in RUN is ignored. Operands cannot change mid-operation.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- sum and cout change only on entry to DONE or on reset. They never show partial results.

## Timing

- Let E0 be the rising edge that samples start=1.
- busy is high after E0 through edge E(WIDTH-1).
- done, sum and cout are valid after edge E(WIDTH). Latency is WIDTH cycles.
- done deasserts after E(WIDTH+1) unless a back-to-back start re-enters RUN.
- done is never high in a cycle where busy is high.
- Minimum issue interval is WIDTH+1 cycles, using back-to-back start in DONE.
- The counter is $clog2(WIDTH) bits wide.
- rst asserted mid-RUN:
  - The next cycle is IDLE with all outputs 0.
  - No done pulse is produced for the aborted operation.

## Configuration

- Macro: SERIAL_ADDER_SUB_EN.
- When defined:
  - The sub port exists and is captured with start.
  - If sub=1: B is loaded bitwise-inverted and the carry flop is loaded with 1; cin is ignored.
  - Result: sum = a - b modulo 2^WIDTH.
  - cout = 1 means no borrow (a >= b unsigned).
  - If sub=0: behaviour is identical to addition.
- When undefined: there is no sub port and the block performs addition only.

## Test plan

All scenarios use WIDTH=8.
- Reset: hold rst=1 for 2 cycles with start=1 -> busy=0, done=0, sum=8'h00, cout=0; state stays IDLE.
- Basic add: a=8'h0F, b=8'h01, cin=0, start pulse -> done exactly 8 edges after the start edge, sum=8'h10, cout=0; busy high for 8 cycles.
- Carry chain:
  - a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
  - a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Ignored start: at RUN cycle 3, start=1 with a=8'h55, b=8'h55 -> result is still from the original operands; no extra done.
- Mid-run reset and back-to-back:
  - rst at RUN cycle 4 -> IDLE, sum=0, no done.
  - Then start in IDLE and again during the DONE cycle -> two correct results 9 cycles apart.
- SERIAL_ADDER_SUB_EN:
  - a=8'h05, b=8'h07, sub=1 -> sum=8'hFE, cout=0.
  - a=8'h07, b=8'h05, sub=1 -> sum=8'h02, cout=1.
